xbar_scheduler: RTL and testbench
=================================

# xbar_scheduler

Per-output round-robin scheduler for the 4x4 router crossbar. Each input port presents at most one request per cycle, tagged with its routed output port. For every output port that can accept a packet, the block grants exactly one contending input, drives the crossbar mux selects, and updates a per-output rotating-priority pointer. Per-input wait-age counters flag starvation for monitoring and verification. It sits between the static routing table and the crossbar datapath, replacing the single global grant rotation.

## Interface
- STARVE_LIMIT, 7, consecutive ungranted request cycles after which an input's starve flag asserts (1..15)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  4  input i has a packet available
- req_port  in  4x2  routed output port for input i; ignored when req_valid[i]=0
- ob_ready  in  4  output buffer j can accept a packet this cycle
- grant  out  4  input i wins this cycle; drives read_from_ib[i]
- out_valid  out  4  output j receives a packet this cycle
- out_sel  out  4x2  input index driving output j; 0 when out_valid[j]=0
- starve_flag  out  4  input i age >= STARVE_LIMIT
- ptr_dbg  out  4x2  current priority pointer per output

## Operation
- Candidate set C_j = {i : req_valid[i] && req_port[i]==j}.
- If ob_ready[j]=1 and C_j is non-empty, the winner w_j is the first i in C_j in search order ptr[j], ptr[j]+1, ... (mod 4). Set out_valid[j]=1, out_sel[j]=w_j, grant[w_j]=1.
- If ob_ready[j]=0, output j grants nothing and ptr[j] holds.
- An input requests only one output per cycle, so grant has no input-side conflict. grant[i]=1 implies req_valid[i]=1.
- Pointer update at the clock edge: if out_valid[j], ptr[j] <= out_sel[j]+1 (2-bit wrap, 3 goes to 0). Otherwise ptr[j] holds.
- Age per input, 4 bits, saturating at 15, updated at the edge:
  - req_valid[i] && !grant[i]: age+1.
  - grant[i], or !req_valid[i]: age cleared to 0.
- starve_flag[i] = (age[i] >= STARVE_LIMIT), registered value.
- An uncontended request with ob_ready set is granted with no arbitration penalty.
- All outputs are forced to 0 while reset_n=0.

## Timing
- grant, out_valid and out_sel are combinational from req_valid, req_port, ob_ready and the registered ptr. Latency is 0 cycles: the crossbar and buffer reads happen in the same cycle.
- ptr, age and starve_flag change only on the rising clock edge, or asynchronously on reset.
- Reset values:
  - ptr = 0 for all outputs (ptr_dbg = 0).
  - age = 0 and starve_flag = 0.
  - grant, out_valid, out_sel = 0.
- Reset asserted mid-operation clears all state immediately. The first post-reset grant to a contended output goes to the lowest-index contender.
- Simultaneous events in one cycle: all four outputs arbitrate independently and may all grant. The maximum is 4 grants per cycle.
- req_port changing while not granted is legal. The new port is used that cycle, and age keeps counting.
- Fairness bound: with ob_ready[j] held high, a continuously requesting input waits at most 3 grants of output j.

## Structure
- Shared router package holds:
  - NUM_PORTS=4
  - port_idx_t (logic [1:0])
  - age_t (logic [3:0])
  - STARVE_LIMIT default
- Sub-module rr_pick4: a combinational 4-way rotating-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once per output port.
- The top level holds the candidate decode, the pointer and age registers, and the output gating.

## Test plan
- Reset check: reset_n=0 with all req_valid=1 -> grant=0, out_valid=0, ptr_dbg=0, starve_flag=0; on release, inputs 0..3 all targeting port 2 -> grant=0001, out_sel[2]=0.
- Rotation: inputs 0..3 all target port 1, ob_ready=1111, held for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,...; ptr_dbg[1] goes 0,1,2,3,0.
- Disjoint parallel: req_port = {3,2,1,0} for inputs {0,1,2,3} -> grant=1111, out_sel[j]=3-j, all four pointers update in one cycle.
- Backpressure: inputs 1 and 2 target port 0 with ob_ready[0]=0 for 10 cycles -> no grants, ptr[0] holds, starve_flag[1] and starve_flag[2] rise after the 7th edge; ob_ready[0]=1 -> input 1 granted and its age clears.
- Pointer skip: ptr[3]=2, only inputs 0 and 1 request port 3 -> input 0 granted, ptr[3] becomes 1.
- Reset mid-stream: assert reset_n low asynchronously between edges during rotation -> outputs are 0 immediately, and state is at reset values at the next edge.

Source files
------------

// File: rtl/xbar_scheduler_pkg.sv
// Shared router package for the 4x4 crossbar scheduler.
// Holds port count, index/age types, the default starvation threshold and
// a saturating age increment helper used by the scheduler top level.
package xbar_scheduler_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;
  typedef logic [3:0] age_t;

  localparam age_t AGE_MAX = 4'hF;

  // Consecutive ungranted request cycles before an input is flagged starving.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 7;

  // Saturating +1 on a wait-age counter.
  function automatic age_t age_inc(input age_t a);
    return (a == AGE_MAX) ? AGE_MAX : a + age_t'(1);
  endfunction

endpackage

// File: rtl/xbar_scheduler_if.sv
// Request/grant bundle between the input buffers, output buffers and the
// crossbar scheduler.
//   req_valid : input i has a packet available
//   req_port  : routed output port per input
//   ob_ready  : output buffer j can accept a packet
//   grant     : input i wins this cycle (read strobe for its buffer)
//   out_valid : output j receives a packet this cycle
//   out_sel   : crossbar mux select per output
// master drives requests/ready, slave (the scheduler) drives grants/selects.
interface xbar_scheduler_if
  import xbar_scheduler_pkg::*;
();

  logic      [NUM_PORTS-1:0] req_valid;
  port_idx_t [NUM_PORTS-1:0] req_port;
  logic      [NUM_PORTS-1:0] ob_ready;
  logic      [NUM_PORTS-1:0] grant;
  logic      [NUM_PORTS-1:0] out_valid;
  port_idx_t [NUM_PORTS-1:0] out_sel;

  modport master (
    output req_valid,
    output req_port,
    output ob_ready,
    input  grant,
    input  out_valid,
    input  out_sel
  );

  modport slave (
    input  req_valid,
    input  req_port,
    input  ob_ready,
    output grant,
    output out_valid,
    output out_sel
  );

endinterface

// File: rtl/xbar_scheduler_rr_pick4.sv
// Combinational 4-way rotating-priority picker.
//   req   : request vector, one bit per contender
//   ptr   : index searched first; search continues ptr+1, ptr+2, ... mod 4
//   found : at least one request present
//   idx   : index of the first request in search order (0 when none)
module rr_pick4
  import xbar_scheduler_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic                 found,
  output port_idx_t            idx
);

  port_idx_t cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // 2-bit add wraps naturally, giving the mod-4 search order.
      cand = ptr + port_idx_t'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xbar_scheduler.sv
// Per-output round-robin scheduler for the 4x4 router crossbar.
// Each output independently picks one contending input using its own
// rotating priority pointer; grants, output valids and mux selects are
// combinational (zero latency) from the request bundle and registered
// pointers. Per-input saturating wait-age counters drive registered
// starvation flags for monitoring.
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset; forces all outputs to 0
//   bus         : request/grant bundle (slave side)
//   starve_flag : input i has waited >= STARVE_LIMIT consecutive cycles
//   ptr_dbg     : current priority pointer per output
module xbar_scheduler
  import xbar_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  xbar_scheduler_if.slave           bus,
  output logic      [NUM_PORTS-1:0] starve_flag,
  output port_idx_t [NUM_PORTS-1:0] ptr_dbg
);

  localparam age_t StarveThresh = age_t'(STARVE_LIMIT);

  // cand[j][i]: input i is requesting output j this cycle.
  logic      [NUM_PORTS-1:0][NUM_PORTS-1:0] cand;
  logic      [NUM_PORTS-1:0]                found;
  port_idx_t [NUM_PORTS-1:0]                pick_idx;

  port_idx_t [NUM_PORTS-1:0] ptr_q, ptr_d;
  age_t      [NUM_PORTS-1:0] age_q, age_d;
  logic      [NUM_PORTS-1:0] starve_q, starve_d;

  logic      [NUM_PORTS-1:0] grant;
  logic      [NUM_PORTS-1:0] out_valid;
  port_idx_t [NUM_PORTS-1:0] out_sel;

  // Candidate decode.
  always_comb begin
    cand = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[j][i] = bus.req_valid[i] && (bus.req_port[i] == port_idx_t'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_pick
    rr_pick4 u_pick (
      .req   (cand[j]),
      .ptr   (ptr_q[j]),
      .found (found[j]),
      .idx   (pick_idx[j])
    );
  end

  // Output gating. Each input targets only one output, so the per-output
  // winners are always distinct inputs and grant bits never collide.
  always_comb begin
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (reset_n && bus.ob_ready[j] && found[j]) begin
        out_valid[j]         = 1'b1;
        out_sel[j]           = pick_idx[j];
        grant[pick_idx[j]]   = 1'b1;
      end
    end
  end

  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;
  assign bus.out_sel   = out_sel;

  // Pointer moves just past the winner; held when the output did not grant.
  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (out_valid[j]) begin
        ptr_d[j] = out_sel[j] + port_idx_t'(1);
      end
    end
  end

  // Wait age counts only consecutive ungranted requesting cycles.
  always_comb begin
    age_d    = '0;
    starve_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.req_valid[i] && !grant[i]) begin
        age_d[i] = age_inc(age_q[i]);
      end else begin
        age_d[i] = '0;
      end
      starve_d[i] = (age_d[i] >= StarveThresh);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      age_q    <= '0;
      starve_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  assign starve_flag = starve_q;
  assign ptr_dbg     = ptr_q;

  // Structural sanity: a grant only ever goes to a requesting input, and
  // every granting output maps to exactly one granted input.
  a_grant_req : assert property (@(posedge clock) disable iff (!reset_n)
    (grant & ~bus.req_valid) == '0);
  a_grant_cnt : assert property (@(posedge clock) disable iff (!reset_n)
    $countones(grant) == $countones(out_valid));

endmodule

// File: tb/tb_xbar_scheduler.sv
module tb_xbar_scheduler;
  import xbar_scheduler_pkg::*;

  localparam int unsigned LIMIT = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] starve_flag;
  logic [7:0] ptr_dbg;

  xbar_scheduler_if bus ();

  xbar_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .starve_flag (starve_flag),
    .ptr_dbg     (ptr_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: per-output pointer and per-input age as plain integers.
  int m_ptr [4];
  int m_age [4];

  typedef struct {
    logic [3:0] v;
    logic [7:0] p;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] ov;
    logic [7:0] sel;
    logic [7:0] ptr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ptr[k] = 0;
      m_age[k] = 0;
    end
  endtask

  // Drive one cycle, check against the reference model, then advance it.
  task automatic mstep(input logic [3:0] v, input logic [7:0] p, input logic [3:0] r);
    logic [3:0] eg, eov, est;
    logic [7:0] esel, eptr;
    int         win [4];
    int         i;
    bus.req_valid = v;
    bus.req_port  = p;
    bus.ob_ready  = r;
    eg = '0; eov = '0; esel = '0; eptr = '0; est = '0;
    for (int j = 0; j < 4; j++) begin
      win[j] = -1;
      if (r[j]) begin
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr[j] + k) % 4;
          if (win[j] < 0 && v[i] && p[2*i +: 2] == 2'(j)) win[j] = i;
        end
      end
      if (win[j] >= 0) begin
        eov[j]         = 1'b1;
        esel[2*j +: 2] = 2'(win[j]);
        eg[win[j]]     = 1'b1;
      end
      eptr[2*j +: 2] = 2'(m_ptr[j]);
      est[j]         = (m_age[j] >= int'(LIMIT));
    end
    @(negedge clock);
    chk("m_grant", bus.grant, eg);
    chk("m_out_valid", bus.out_valid, eov);
    chk("m_out_sel", bus.out_sel, esel);
    chk("m_ptr_dbg", ptr_dbg, eptr);
    chk("m_starve", starve_flag, est);
    @(posedge clock);
    for (int j = 0; j < 4; j++) begin
      if (win[j] >= 0) m_ptr[j] = (win[j] + 1) % 4;
      if (v[j] && !eg[j]) m_age[j] = (m_age[j] < 15) ? m_age[j] + 1 : 15;
      else m_age[j] = 0;
    end
    #1;
  endtask

  initial begin
    //                v      p      r      g      ov     sel    ptr
    tbl[0] = '{4'hF, 8'hAA, 4'hF, 4'h1, 4'h4, 8'h00, 8'h00};
    tbl[1] = '{4'hF, 8'hAA, 4'hF, 4'h2, 4'h4, 8'h10, 8'h10};
    tbl[2] = '{4'hF, 8'hAA, 4'hF, 4'h4, 4'h4, 8'h20, 8'h20};
    tbl[3] = '{4'hF, 8'hAA, 4'hF, 4'h8, 4'h4, 8'h30, 8'h30};
    tbl[4] = '{4'hF, 8'h1B, 4'hF, 4'hF, 4'hF, 8'h1B, 8'h00};
    tbl[5] = '{4'h2, 8'h0C, 4'hF, 4'h2, 4'h8, 8'h40, 8'h6C};
    tbl[6] = '{4'h3, 8'h0F, 4'hF, 4'h1, 4'h8, 8'h00, 8'hAC};
    tbl[7] = '{4'h0, 8'h00, 4'hF, 4'h0, 4'h0, 8'h00, 8'h6C};

    // Reset holds every output low even with all inputs requesting.
    bus.req_valid = 4'hF;
    bus.req_port  = 8'hAA;
    bus.ob_ready  = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", bus.grant, 8'h00);
    chk("rst_out_valid", bus.out_valid, 8'h00);
    chk("rst_out_sel", bus.out_sel, 8'h00);
    chk("rst_ptr_dbg", ptr_dbg, 8'h00);
    chk("rst_starve", starve_flag, 8'h00);
    reset_n = 1'b1;

    // Table: rotation on port 2, disjoint parallel, pointer skip.
    for (int n = 0; n < 8; n++) begin
      bus.req_valid = tbl[n].v;
      bus.req_port  = tbl[n].p;
      bus.ob_ready  = tbl[n].r;
      @(negedge clock);
      chk($sformatf("tbl%0d_grant", n), bus.grant, tbl[n].g);
      chk($sformatf("tbl%0d_out_valid", n), bus.out_valid, tbl[n].ov);
      chk($sformatf("tbl%0d_out_sel", n), bus.out_sel, tbl[n].sel);
      chk($sformatf("tbl%0d_ptr_dbg", n), ptr_dbg, tbl[n].ptr);
      chk($sformatf("tbl%0d_starve", n), starve_flag, 8'h00);
      @(posedge clock);
      #1;
    end

    // Backpressure: inputs 1,2 blocked on port 0 for 10 cycles.
    bus.req_valid = 4'h6;
    bus.req_port  = 8'h00;
    bus.ob_ready  = 4'hE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("bp_grant", bus.grant, 8'h00);
      chk("bp_out_valid", bus.out_valid, 8'h00);
      chk("bp_ptr_dbg", ptr_dbg, 8'h6C);
      chk($sformatf("bp_starve_c%0d", c), starve_flag, (c >= 7) ? 8'h06 : 8'h00);
      @(posedge clock);
      #1;
    end
    bus.ob_ready = 4'hF;
    @(negedge clock);
    chk("bp_rel_grant", bus.grant, 8'h02);
    chk("bp_rel_out_valid", bus.out_valid, 8'h01);
    chk("bp_rel_out_sel", bus.out_sel, 8'h01);
    chk("bp_rel_starve", starve_flag, 8'h06);
    @(posedge clock);
    #1;
    bus.req_valid = 4'h0;
    @(negedge clock);
    chk("bp_after_starve", starve_flag, 8'h04);
    chk("bp_after_ptr_dbg", ptr_dbg, 8'h6E);
    @(posedge clock);
    #1;

    // Fresh start for model-driven checking.
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Rotation on port 1, then two more so the pointer sits mid-cycle.
    for (int n = 0; n < 10; n++) mstep(4'hF, 8'h55, 4'hF);

    // Asynchronous reset between edges.
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 8'h00);
    chk("mid_rst_out_valid", bus.out_valid, 8'h00);
    chk("mid_rst_out_sel", bus.out_sel, 8'h00);
    chk("mid_rst_ptr_dbg", ptr_dbg, 8'h00);
    chk("mid_rst_starve", starve_flag, 8'h00);
    bus.req_valid = 4'h0;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_hold_ptr", ptr_dbg, 8'h00);
    reset_n = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    mstep(4'hF, 8'h55, 4'hF);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rv, rr;
      logic [7:0] rp;
      rv = 4'($urandom);
      rp = 8'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      mstep(rv, rp, rr);
    end

    // Long blockage drives ages into saturation, then release.
    for (int n = 0; n < 20; n++) mstep(4'hF, 8'h00, 4'h0);
    for (int n = 0; n < 4; n++) mstep(4'hF, 8'h00, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
